// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder / IMEM loader.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_ADDI = 3'd4
    } kind_e;

    // Opcodes as decoded by the single-cycle core.
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer with legality flag.
// Legality checks exist only when ENCODER_CHECK_EN is defined; otherwise o_legal is always 1.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  i_kind,
    input  logic [3:0]  i_funct,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    logic [6:0] w_f7;
    logic [2:0] w_f3;

    assign w_f7 = i_funct[3] ? 7'b0100000 : 7'b0000000;
    assign w_f3 = i_funct[2:0];

    always_comb begin
        o_word = NOP_WORD;
        case (i_kind)
            KIND_R:    o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, OPC_R};
            KIND_LW:   o_word = {i_imm[11:0], i_rs1, 3'b010, i_rd, OPC_LOAD};
            KIND_SW:   o_word = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OPC_STORE};
            KIND_BEQ:  o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, 3'b000,
                                 i_imm[4:1], i_imm[11], OPC_BRANCH};
            KIND_ADDI: o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, OPC_OPIMM};
            default:   o_word = NOP_WORD;
        endcase
    end

`ifdef ENCODER_CHECK_EN
    logic w_imm12_fits;

    // A 13-bit value fits in 12 signed bits when its top two bits agree.
    assign w_imm12_fits = (i_imm[12] == i_imm[11]);

    always_comb begin
        o_legal = 1'b0;
        case (i_kind)
            KIND_R:                       o_legal = 1'b1;
            KIND_LW, KIND_SW, KIND_ADDI:  o_legal = w_imm12_fits;
            KIND_BEQ:                     o_legal = ~i_imm[0];
            default:                      o_legal = 1'b0;
        endcase
    end
`else
    assign o_legal = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder that loads consecutive IMEM words from address 0.
// Define ENCODER_CHECK_EN to drop illegal inputs and report them on err.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_funct,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    state_e              r_state, w_state_d;
    logic [ADDR_W:0]     r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_done;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_xfer;
    logic                w_write;
    logic                w_fill;
    logic                w_enter_load;

    instr_pack u_pack (
        .i_kind  (in_kind),
        .i_funct (in_funct),
        .i_rd    (in_rd),
        .i_rs1   (in_rs1),
        .i_rs2   (in_rs2),
        .i_imm   (in_imm),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    // count already includes the in-flight write, so it alone bounds acceptance.
    assign in_ready     = (r_state == ST_LOAD) && (r_count < CNT_FULL);
    assign w_xfer       = in_valid && in_ready;
    assign w_write      = w_xfer && w_legal;
    assign w_fill       = w_write && (r_count == CNT_FULL - CNT_ONE);
    assign w_enter_load = (r_state != ST_LOAD) && (w_state_d == ST_LOAD);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_d = ST_LOAD;
            ST_LOAD: if (w_xfer && (in_last || w_fill)) w_state_d = ST_DONE;
            ST_DONE: if (start) w_state_d = ST_LOAD;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_we    <= w_write;
            // done trails entry into DONE by one cycle so it follows the final write.
            r_done  <= (r_state == ST_DONE) && (w_state_d == ST_DONE);
            if (w_enter_load) begin
                r_count <= '0;
            end else if (w_write) begin
                r_count <= r_count + CNT_ONE;
            end
            if (w_write) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= w_word;
            end
        end
    end

`ifdef ENCODER_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_enter_load) begin
            r_err <= 1'b0;
        end else if (w_xfer && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;

endmodule
